// File: rtl/csa_stream_accumulator_if.sv
// Operand/result stream bundle for csa_stream_accumulator.
interface csa_stream_accumulator_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_signed;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in_data, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation of one operand per
// beat, followed by a chunked carry-propagate resolve and a held result.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  csa_stream_accumulator_if.slave   bus
);

  localparam int unsigned NCHUNK = ACC_W / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Elaboration-time parameter sanity.
  if (ACC_W < WIDTH) begin : g_bad_width
    $error("csa_stream_accumulator: ACC_W must be >= WIDTH");
  end
  if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_stream_accumulator: ACC_W must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] s_q;
  logic [ACC_W-1:0] c_q;
  logic [ACC_W-1:0] r_q;
  logic [KW-1:0]    k_q;
  logic             cy_q;
  logic             out_valid_q;

  logic [ACC_W-1:0] ext_c;
  logic [ACC_W-1:0] s_next_c;
  logic [ACC_W-1:0] c_next_c;
  logic [CHUNK-1:0] s_chunk_c;
  logic [CHUNK-1:0] c_chunk_c;
  logic [CHUNK:0]   chunk_sum_c;
  logic             accept_c;
  logic             deliver_c;
  logic             last_chunk_c;

  // Handshake outputs; in_ready is held low while reset is asserted.
  assign bus.in_ready  = rst_n & (state_q == ST_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = r_q;

  assign accept_c     = bus.in_valid & bus.in_ready;
  assign deliver_c    = out_valid_q & bus.out_ready;
  assign last_chunk_c = (k_q == KW'(NCHUNK - 1));

  // Operand extension to accumulator width.
  always_comb begin
    ext_c = ACC_W'(bus.in_data);
    if (bus.in_signed) begin
      ext_c = ACC_W'($signed(bus.in_data));
    end
  end

  // Full-adder row: three inputs (S, C, E) reduce to a new (S, C) pair.
  always_comb begin
    s_next_c = s_q ^ c_q ^ ext_c;
    c_next_c = ((s_q & c_q) | (s_q & ext_c) | (c_q & ext_c)) << 1;
  end

  // One CHUNK-wide slice of the carry-propagate add per resolve cycle.
  always_comb begin
    s_chunk_c   = s_q[k_q * CHUNK +: CHUNK];
    c_chunk_c   = c_q[k_q * CHUNK +: CHUNK];
    chunk_sum_c = (CHUNK+1)'(s_chunk_c) + (CHUNK+1)'(c_chunk_c)
                + (CHUNK+1)'(cy_q);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept_c) begin
            s_q <= s_next_c;
            c_q <= c_next_c;
            if (bus.in_last) begin
              state_q <= ST_RESOLVE;
              k_q     <= '0;
              cy_q    <= 1'b0;
            end
          end
        end

        ST_RESOLVE: begin
          r_q[k_q * CHUNK +: CHUNK] <= chunk_sum_c[CHUNK-1:0];
          cy_q                      <= chunk_sum_c[CHUNK];
          k_q                       <= k_q + KW'(1);
          // Carry out of the top chunk is dropped: result is mod 2^ACC_W.
          if (last_chunk_c) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            k_q         <= '0;
          end
        end

        ST_OUT: begin
          if (deliver_c) begin
            s_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end

        default: begin
          state_q     <= ST_ACC;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Parametrised streaming multi-operand adder for the multiplier datapath. Extends the single-bit full-adder cell to a WIDTH-wide carry-save row that accumulates a packet of operands in redundant (sum, carry) form, one operand per cycle.
- On the packet's last beat, a chunked carry-propagate phase resolves the result over several cycles.
- Used to sum partial products or partial results from iterative multiplier passes.
- Adds a valid/ready handshake on both sides and per-beat signed/unsigned extension.

Parameters:
- WIDTH, 32, input operand width in bits.
- ACC_W, 40, accumulator/result width; must satisfy ACC_W >= WIDTH and ACC_W % CHUNK == 0.
- CHUNK, 8, bits resolved per cycle in the carry-propagate phase; NCHUNK = ACC_W/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  operand.
- in_signed  input  1  1 = sign-extend in_data to ACC_W; 0 = zero-extend.
- in_last  input  1  marks final beat of packet.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  ACC_W  resolved sum, modulo 2^ACC_W.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - S, C, result register, chunk index and carry flop all cleared to 0; state = ACC.
  - out_valid=0, out_data=0.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - Reset takes priority over every other event in any state, including mid-RESOLVE and OUT; a partial packet is discarded.
- States: ACC, RESOLVE, OUT.
- ACC:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: E = extend(in_data, in_signed) to ACC_W bits.
  - Bitwise full-adder row: S <= S^C^E; C <= ((S&C)|(S&E)|(C&E)) << 1, dropping the MSB (mod 2^ACC_W).
  - If in_last is set on the same beat: state <= RESOLVE, chunk index k <= 0, carry flop cy <= 0.
  - Packet length is 1..unbounded; a single beat with in_last yields E itself.
- RESOLVE:
  - in_ready=0; in_valid is ignored, with no backpressure violation.
  - Each cycle: {cy, R[k*CHUNK +: CHUNK]} <= S[k-chunk] + C[k-chunk] + cy; k <= k+1.
  - After chunk NCHUNK-1: state <= OUT, out_valid <= 1; the final cy is discarded (wrap-around).
- Latency:
  - Last-beat handshake in cycle T; RESOLVE occupies cycles T+1..T+NCHUNK; out_valid=1 from cycle T+NCHUNK+1.
  - With defaults, out_valid rises 6 cycles after the last beat.
- OUT:
  - out_valid=1; out_data = R, held stable until handshake; in_ready=0.
  - On out_valid&out_ready: S<=0, C<=0, out_valid<=0, state <= ACC.
  - in_ready returns to 1 the following cycle; there is no same-cycle bypass.
- Arithmetic:
  - Result equals the sum of all extended beats mod 2^ACC_W, regardless of signed/unsigned mix.
  - No overflow flag.
- out_data is registered (R), changes only during RESOLVE/reset, and is 0 after reset.
- Throughput: one beat per cycle in ACC; NCHUNK+2 cycles minimum of packet overhead.

Test Plan:
- Unsigned 0xFFFFFFFF x3, last on beat 3 → out_data=0x02FFFFFFFD; out_valid first high exactly 6 cycles after the last handshake; in_ready=0 during those cycles.
- Signed 0xFFFFFFFF (-1) then signed 0x00000005 (last) → 0x0000000004.
- Mixed modes: unsigned 0xFFFFFFFF then signed 0xFFFFFFFF (last) → 0x00FFFFFFFE.
- Wrap-around:
  - 256 signed beats of 0x80000000 → 0x8000000000.
  - Next packet of 512 identical beats → 0x0000000000.
- Backpressure:
  - Single beat 0x1234 last, out_ready=0 for 10 cycles → out_valid held, out_data stable at 0x0000001234, in_valid beats ignored.
  - After the handshake, in_ready=1 next cycle.
  - Packet 0x1 (last) → 0x0000000001, proving accumulator clear.
- Reset mid-packet: 0x7 accepted, last 0x9 accepted, rst_n=0 in 2nd RESOLVE cycle → out_valid=0, out_data=0, in_ready=0 during reset. After release, packet 0x7, 0x8 (last) → 0x000000000F.
